// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op-code and state encodings shared by the sequential shifter
package shift_pkg;

    // Shift operation codes; lsl and lsa behave identically
    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_RSL = 2'b01;
    localparam logic [1:0] OP_LSA = 2'b10;
    localparam logic [1:0] OP_RSA = 2'b11;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-position shift selected by op
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    // One-bit shift: left ops zero-fill the LSB, rsl zero-fills the MSB, rsa keeps the sign
    always_comb begin
        result = data;
        case (op)
            OP_LSL, OP_LSA: result = {data[WIDTH-2:0], 1'b0};
            OP_RSL:         result = {1'b0, data[WIDTH-1:1]};
            default:        result = {data[WIDTH-1], data[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle shifter, one bit position per clock with start/done handshake
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] num,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] step_result;
    logic             done_q;
    logic [WIDTH-1:0] out_q;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data  (work),
        .op    (op_q),
        .result(step_result)
    );

    // FSM, counter and datapath; out/done load on the edge entering DONE so out is valid with done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= '0;
            op_q   <= OP_LSL;
            done_q <= 1'b0;
            out_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work <= in;
                        cnt  <= num;
                        op_q <= op;
                        if (num != '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            state  <= ST_DONE;
                            out_q  <= in;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= step_result;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= ST_DONE;
                        out_q  <= step_result;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - self-checking bench for shift_seq with vector table, random ops and corner sequences
module tb_shift_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef struct {
        logic [7:0] a;
        logic [2:0] n;
        logic [1:0] o;
        logic [7:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] in_d = '0;
    logic [CNT_W-1:0] num_d = '0;
    logic [1:0]       op_d = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_d;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_seq #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .in   (in_d),
        .num  (num_d),
        .op   (op_d),
        .busy (busy),
        .done (done),
        .out  (out_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input int n, input logic [1:0] o);
        logic signed [7:0] s;
        s = a;
        case (o)
            2'b00, 2'b10: return 8'((int'(a) << n) & 255);
            2'b01:        return 8'(int'(a) >> n);
            default:      return 8'(s >>> n);
        endcase
    endfunction

    // Capture one operation, scramble inputs afterwards, optionally pulse start at cycle inject_k
    task automatic run_op(input string name, input logic [7:0] a, input logic [2:0] n,
                          input logic [1:0] o, input logic [7:0] exp, input int inject_k);
        int k;
        @(negedge clk);
        in_d = a; num_d = n; op_d = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_d = 8'($urandom); num_d = 3'($urandom); op_d = 2'($urandom);
        for (k = 1; k <= 20; k++) begin
            start = (k == inject_k);
            if (k == inject_k) begin
                in_d = ~a; num_d = 3'd1; op_d = ~o;
            end
            if (done || !busy) break;
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("%s latency", name), k, 32'(n) + 1);
        check($sformatf("%s out", name), out_d, exp);
        check($sformatf("%s busy_at_done", name), busy, 1);
        @(negedge clk);
        check($sformatf("%s idle_after", name), {busy, done}, 0);
        check($sformatf("%s out_hold", name), out_d, exp);
    endtask

    initial begin
        vec_t tbl[8];
        bit   seen;
        logic [7:0] ra;
        logic [2:0] rn;
        logic [1:0] ro;

        tbl[0] = '{8'h08, 3'd4, 2'b00, 8'h80};
        tbl[1] = '{8'h08, 3'd4, 2'b01, 8'h00};
        tbl[2] = '{8'hF4, 3'd4, 2'b01, 8'h0F};
        tbl[3] = '{8'hF4, 3'd4, 2'b11, 8'hFF};
        tbl[4] = '{8'hD7, 3'd3, 2'b10, 8'hB8};
        tbl[5] = '{8'h96, 3'd5, 2'b11, 8'hFC};
        tbl[6] = '{8'h18, 3'd2, 2'b00, 8'h60};
        tbl[7] = '{8'h81, 3'd7, 2'b11, 8'hFF};

        // Reset held across two rising edges
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out", out_d, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].n, tbl[i].o, tbl[i].exp, 0);
        end

        // num = 0 completes the cycle after capture
        run_op("num0", 8'hA5, 3'd0, 2'b00, 8'hA5, 0);
        // start pulsed during a six-step shift is ignored
        run_op("ignore_start", 8'h3C, 3'd6, 2'b01, 8'h00, 3);
        run_op("ignore_start2", 8'hC3, 3'd6, 2'b11, 8'hFF, 2);

        // Reset in the middle of a shift aborts without a done pulse
        @(negedge clk);
        in_d = 8'h5A; num_d = 3'd6; op_d = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst out", out_d, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midrst quiet", seen, 0);
        run_op("post_rst", 8'h18, 3'd2, 2'b00, 8'h60, 0);

        // Randomised operations against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rn = 3'($urandom_range(0, 7));
            ro = 2'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", i), ra, rn, ro, model(ra, int'(rn), ro), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift unit: accepts an operand, shift amount and operation code through a start/done handshake, shifts one bit position per clock, and returns the registered result. It is the sequential counterpart of the combinational `shift` operator block and produces identical results for the same inputs. It is used where a barrel shifter is too large or where the shift result feeds registered datapath logic.

## Interface

- `WIDTH`, 8, operand/result width in bits.
- `CNT_W`, 3, shift-amount width; equals clog2(`WIDTH`).
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, synchronous and active-low.
- `start`  input  1  request; sampled only in IDLE.
- `in`  input  `WIDTH`  operand, captured with `start`.
- `num`  input  `CNT_W`  shift amount, 0..`WIDTH`-1, captured with `start`.
- `op`  input  2  00 = lsl, 01 = rsl, 10 = lsa, 11 = rsa; captured with `start`.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse; `out` is valid from this cycle on.
- `out`  output  `WIDTH`  result register; holds its value until the next `done`.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE with `start`=1: load work register with `in`, counter with `num`, latch `op`. Go to SHIFT if `num`≠0, else go to DONE.
- IDLE with `start`=0: stay in IDLE.
- SHIFT, each cycle: shift the work register by 1 per the latched op, decrement the counter. Go to DONE when the counter goes 1→0.
- DONE: `out` ← work register, `done`=1, go to IDLE unconditionally.
- Shift rules:
  - lsl and lsa are identical; zero fills the LSB.
  - rsl fills the MSB with zero.
  - rsa replicates the MSB.
- `start` while `busy`: ignored. No queuing, no error flag.
- `in`, `num` and `op` may change after capture with no effect on the operation in flight.
- `start` held high continuously: a new operation is accepted on every IDLE cycle, so back-to-back operations have one IDLE cycle between `done` and the next capture.

## Timing

- Reset (`rst_n`=0 at a rising edge): state=IDLE, `busy`=0, `done`=0, `out`=0, work register=0, counter=0.
- Reset mid-operation aborts the operation. `out` is cleared, not updated, and no `done` is produced.
- Latency: `start` sampled at edge T → `done` high during cycle T+`num`+1.
  - `num`=0: `done` in the cycle after capture, `out`=`in`.
  - `num`=7: `done` 8 cycles after capture.
- `busy` rises the cycle after capture and falls the cycle after `done`. It is high for `num`+1 cycles.
- `out` and `done` are registered outputs; there are no combinational paths from inputs to outputs.

## Structure

- Package `shift_pkg`:
  - op-code localparams `OP_LSL`, `OP_RSL`, `OP_LSA`, `OP_RSA`.
  - state encoding `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
- Sub-module `shift_step`: combinational single-bit shift of a `WIDTH` vector selected by `op`. It is instantiated once in the datapath.
- Everything else (FSM, counter, work register, `out` register) lives in `shift_seq`.

## Test plan

- Reset check: assert `rst_n`=0 for 2 cycles → `out`=0x00, `busy`=0, `done`=0.
- `in`=0x08, `num`=4, `op`=lsl → `out`=0x80, `done` 5 cycles after capture. Repeat with `op`=rsl → `out`=0x00.
- `in`=0xF4, `num`=4: `op`=rsl → `out`=0x0F; `op`=rsa → `out`=0xFF.
- `in`=0xD7, `num`=3, `op`=lsa → 0xB8. `in`=0x96, `num`=5, `op`=rsa → 0xFC. `in`=0x18, `num`=2, `op`=lsl → 0x60.
- `num`=0, `in`=0xA5 → `done` one cycle after capture, `out`=0xA5. Then `start` pulsed mid-operation (during a `num`=6 shift) → ignored, and the first result is unchanged.
- `rst_n` low during SHIFT → no `done` pulse, `out`=0x00, next `start` completes normally.
